// File: rtl/convolution_index_ctrl.sv
// convolution_index_ctrl
// Loop sequencer for 1-D convolution y[n] = sum_k x[k]*h[n-k].
// Takes N/M at start and len_y = N+M-1 from convolution_count, then walks n over
// 0..len_y-1 and, for each n, k over the valid taps. It issues x/h read addresses,
// the MAC clear/enable strobes and the y write-back.
//
// Ports
//   clk        clock, all logic on posedge
//   rsth       synchronous active-high reset
//   start_i    1-cycle start pulse, honoured only in idle
//   size_x_i   N, number of x samples
//   size_h_i   M, number of h taps
//   len_y_i    N+M-1 from convolution_count, sampled one cycle after start
//   busy_o     job in progress (load through last write)
//   done_o     1-cycle pulse, job finished or aborted on bad sizes
//   err_o      sticky length/overflow error, cleared by next accepted start
//   rd_en_o    x/h memory read strobe
//   addr_x_o   x read address k
//   addr_h_o   h read address n-k
//   mac_clr_o  clear accumulator, once per output sample
//   mac_en_o   accumulate, rd_en_o delayed by one cycle (memory read latency)
//   y_we_o     write accumulator into y memory
//   addr_y_o   y write address n
module convolution_index_ctrl #(
  parameter int unsigned DATAWIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rsth,
  input  logic                 start_i,
  input  logic [DATAWIDTH-1:0] size_x_i,
  input  logic [DATAWIDTH-1:0] size_h_i,
  input  logic [DATAWIDTH-1:0] len_y_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 rd_en_o,
  output logic [DATAWIDTH-1:0] addr_x_o,
  output logic [DATAWIDTH-1:0] addr_h_o,
  output logic                 mac_clr_o,
  output logic                 mac_en_o,
  output logic                 y_we_o,
  output logic [DATAWIDTH-1:0] addr_y_o
);

  localparam logic [DATAWIDTH-1:0] OneN = DATAWIDTH'(1);
  localparam logic [DATAWIDTH:0]   OneW = (DATAWIDTH + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StClr,
    StInner,
    StDrain,
    StWrite,
    StFin
  } state_e;

  state_e state_q, state_d;

  logic [DATAWIDTH-1:0] size_x_q, size_x_d;
  logic [DATAWIDTH-1:0] size_h_q, size_h_d;
  logic [DATAWIDTH-1:0] len_q, len_d;
  logic [DATAWIDTH-1:0] n_q, n_d;
  logic [DATAWIDTH-1:0] k_q, k_d;
  logic [DATAWIDTH-1:0] k_hi_q, k_hi_d;
  logic [DATAWIDTH-1:0] ax_q, ax_d;
  logic [DATAWIDTH-1:0] ah_q, ah_d;
  logic [DATAWIDTH-1:0] ay_q, ay_d;
  logic                 err_q, err_d;
  logic                 mac_en_q;

  // Bound arithmetic is done one bit wider so N+M-1 overflow and n-M+1 underflow are visible.
  logic [DATAWIDTH:0] n_w, nx_w, mh_w, len_calc, k_lo_w, k_hi_w;

  always_comb begin
    n_w      = {1'b0, n_q};
    nx_w     = {1'b0, size_x_q};
    mh_w     = {1'b0, size_h_q};
    len_calc = nx_w + mh_w - OneW;
    k_lo_w   = (n_w >= mh_w - OneW) ? (n_w - mh_w + OneW) : '0;
    k_hi_w   = (n_w < nx_w - OneW) ? n_w : (nx_w - OneW);
  end

  always_comb begin
    state_d  = state_q;
    size_x_d = size_x_q;
    size_h_d = size_h_q;
    len_d    = len_q;
    n_d      = n_q;
    k_d      = k_q;
    k_hi_d   = k_hi_q;
    ax_d     = ax_q;
    ah_d     = ah_q;
    ay_d     = ay_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          size_x_d = size_x_i;
          size_h_d = size_h_i;
          err_d    = 1'b0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        len_d = len_y_i;
        if (size_x_q == '0 || size_h_q == '0) begin
          state_d = StFin;
        end else if (len_calc != {1'b0, len_y_i} || len_calc[DATAWIDTH]) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          n_d     = '0;
          state_d = StClr;
        end
      end
      StClr: begin
        k_d     = k_lo_w[DATAWIDTH-1:0];
        k_hi_d  = k_hi_w[DATAWIDTH-1:0];
        state_d = StInner;
      end
      StInner: begin
        // Remember the presented addresses so the ports hold them once the strobe drops.
        ax_d = k_q;
        ah_d = n_q - k_q;
        k_d  = k_q + OneN;
        if (k_q == k_hi_q) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StWrite;
      end
      StWrite: begin
        ay_d = n_q;
        if (n_q == len_q - OneN) begin
          state_d = StFin;
        end else begin
          n_d     = n_q + OneN;
          state_d = StClr;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rsth) begin
      state_q  <= StIdle;
      size_x_q <= '0;
      size_h_q <= '0;
      len_q    <= '0;
      n_q      <= '0;
      k_q      <= '0;
      k_hi_q   <= '0;
      ax_q     <= '0;
      ah_q     <= '0;
      ay_q     <= '0;
      err_q    <= 1'b0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_x_q <= size_x_d;
      size_h_q <= size_h_d;
      len_q    <= len_d;
      n_q      <= n_d;
      k_q      <= k_d;
      k_hi_q   <= k_hi_d;
      ax_q     <= ax_d;
      ah_q     <= ah_d;
      ay_q     <= ay_d;
      err_q    <= err_d;
      mac_en_q <= rd_en_o;
    end
  end

  always_comb begin
    busy_o    = (state_q != StIdle) && (state_q != StFin);
    done_o    = (state_q == StFin);
    err_o     = err_q;
    rd_en_o   = (state_q == StInner);
    mac_clr_o = (state_q == StClr);
    mac_en_o  = mac_en_q;
    y_we_o    = (state_q == StWrite);
    addr_x_o  = rd_en_o ? k_q : ax_q;
    addr_h_o  = rd_en_o ? (n_q - k_q) : ah_q;
    addr_y_o  = y_we_o ? n_q : ay_q;
  end

endmodule
